// File: rtl/doom_mem_arbiter.sv
// Round-robin arbiter sharing one 8-bit Avalon-MM master port between NUM_REQ requesters.
// A requester may hold the grant via req_lock for up to LOCK_MAX consecutive transfers.
module doom_mem_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ-1:0]         req_read,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*8-1:0]       req_writedata,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ*8-1:0]       req_readdata,
  output logic [NUM_REQ-1:0]         req_waitrequest,
  output logic [ADDR_W-1:0]          mem_address,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [7:0]                 mem_writedata,
  input  logic [7:0]                 mem_readdata,
  input  logic                       mem_waitrequest,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       busy,
  output logic                       proto_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0]      grant_q;
  logic [CntW-1:0]      lock_cnt_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [7:0]           wdata_q;
  logic                 rd_q, wr_q, busy_q, perr_q;
  logic [NUM_REQ*8-1:0] rdata_q;

  logic [NUM_REQ-1:0] pending;
  logic               grant_now, done, lock_hold, rr_found;
  logic [IdxW-1:0]    rr_idx, sel_idx, cand;
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_wdata;
  logic               sel_rd, sel_wr;

  assign pending   = req_read | req_write;
  assign grant_now = (state_q == StIdle) && (|pending);
  assign done      = (state_q == StIssue) && !mem_waitrequest;

  // Lock re-grant only while the holder still requests and has budget left.
  assign lock_hold = req_lock[grant_q] & pending[grant_q] &
                     (lock_cnt_q < CntW'(LOCK_MAX - 1));

  // First pending requester scanning upward from grant_q+1, wrapping to grant_q itself.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = grant_q;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(grant_q) + k) % NUM_REQ);
      if (!rr_found && pending[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign sel_idx = lock_hold ? grant_q : rr_idx;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_addr  = req_address[i*ADDR_W +: ADDR_W];
        sel_wdata = req_writedata[i*8 +: 8];
        sel_rd    = req_read[i];
        sel_wr    = req_write[i];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|pending) state_d = StIssue;
      StIssue: if (!mem_waitrequest) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered master command, grant bookkeeping and per-lane read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= IdxW'(NUM_REQ - 1);
      lock_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      perr_q <= perr_q | (|(req_read & req_write));
      if (grant_now) begin
        grant_q    <= sel_idx;
        lock_cnt_q <= lock_hold ? lock_cnt_q + 1'b1 : '0;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        // Read+write together resolves to a write.
        rd_q       <= sel_rd & ~sel_wr;
        wr_q       <= sel_wr;
        busy_q     <= 1'b1;
      end else if (done) begin
        rd_q   <= 1'b0;
        wr_q   <= 1'b0;
        busy_q <= 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant_q == IdxW'(i)) rdata_q[i*8 +: 8] <= mem_readdata;
        end
      end
    end
  end

  // FSM outputs: completion pulse and pass-through read data to the granted lane
  always_comb begin
    req_waitrequest = '1;
    req_readdata    = rdata_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (done && (grant_q == IdxW'(i))) begin
        req_waitrequest[i]     = 1'b0;
        req_readdata[i*8 +: 8] = mem_readdata;
      end
    end
  end

  assign mem_address   = addr_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_writedata = wdata_q;
  assign grant_idx     = grant_q;
  assign busy          = busy_q;
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_doom_mem_arbiter.sv
// Bench for doom_mem_arbiter: vector table, directed multi-cycle sequences and a
// randomized run checked against a transaction-level arbitration model.
module tb_doom_mem_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int LM = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR*AW-1:0] req_address;
  logic [NR-1:0]   req_read, req_write, req_lock;
  logic [NR*8-1:0] req_writedata, req_readdata;
  logic [NR-1:0]   req_waitrequest;
  logic [AW-1:0]   mem_address;
  logic            mem_read, mem_write;
  logic [7:0]      mem_writedata, mem_readdata;
  logic            mem_waitrequest;
  logic [1:0]      grant_idx;
  logic            busy, proto_err;

  always #5 clk = ~clk;

  doom_mem_arbiter #(
    .NUM_REQ  (NR),
    .ADDR_W   (AW),
    .LOCK_MAX (LM)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_address     (req_address),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_writedata   (req_writedata),
    .req_lock        (req_lock),
    .req_readdata    (req_readdata),
    .req_waitrequest (req_waitrequest),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .grant_idx       (grant_idx),
    .busy            (busy),
    .proto_err       (proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  rd, wr;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        mw;
    logic [7:0]  mrd;
    logic [2:0]  e_strb;   // {mem_read, mem_write, busy}
    logic [31:0] e_addr;
    logic [7:0]  e_wd;
    logic [2:0]  e_wreq;
    logic [1:0]  e_grant;
    logic [23:0] e_rdata;
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                              input logic [7:0] wd, input logic mw, input logic [7:0] mrd,
                              input logic [2:0] e_strb, input logic [31:0] e_addr,
                              input logic [7:0] e_wd, input logic [2:0] e_wreq,
                              input logic [1:0] e_grant, input logic [23:0] e_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.mw = mw; v.mrd = mrd;
    v.e_strb = e_strb; v.e_addr = e_addr; v.e_wd = e_wd; v.e_wreq = e_wreq;
    v.e_grant = e_grant; v.e_rdata = e_rdata;
    return v;
  endfunction

  int grants[$];

  task automatic do_reset();
    reset           = 1'b1;
    req_read        = '0;
    req_write       = '0;
    req_lock        = '0;
    req_address     = '0;
    req_writedata   = '0;
    mem_waitrequest = 1'b0;
    mem_readdata    = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Called at posedge+1 with stimulus applied; returns at posedge+1.
  task automatic collect(input int n, input int budget);
    int c;
    grants.delete();
    c = 0;
    while (c < budget && grants.size() < n) begin
      #3;
      if (req_waitrequest != 3'b111) grants.push_back(int'(grant_idx));
      @(posedge clk); #1;
      c++;
    end
    chk("collect_count", 64'(grants.size()), 64'(n));
  endtask

  function automatic int grant_at(input int i);
    return (i < grants.size()) ? grants[i] : 99;
  endfunction

  // Random-phase agents and reference model state
  logic [NR-1:0] a_act, a_rd, a_wr, a_lock, pend;
  logic [31:0]   a_addr[NR];
  logic [7:0]    a_wd[NR];
  logic          m_busy, e_rd, e_wr;
  int            m_last, m_cnt, m_w, done_prev, cidx;
  logic [23:0]   m_rdata;
  logic [31:0]   e_addr;
  logic [7:0]    e_wd;
  logic [2:0]    exp_wreq;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(3'b010, 3'b000, 32'h3000_0004, 8'h00, 1'b0, 8'hA5,
                3'b000, 32'h0, 8'h00, 3'b111, 2'd2, 24'h000000);
    tbl[1] = mk(3'b010, 3'b000, 32'h3000_0004, 8'h00, 1'b0, 8'hA5,
                3'b101, 32'h3000_0004, 8'h00, 3'b101, 2'd1, 24'h00A500);
    tbl[2] = mk(3'b000, 3'b000, 32'h0, 8'h00, 1'b0, 8'h00,
                3'b000, 32'h3000_0004, 8'h00, 3'b111, 2'd1, 24'h00A500);
    tbl[3] = mk(3'b000, 3'b001, 32'h3000_0010, 8'h7E, 1'b1, 8'h00,
                3'b000, 32'h3000_0004, 8'h00, 3'b111, 2'd1, 24'h00A500);
    tbl[4] = mk(3'b000, 3'b001, 32'h3000_0010, 8'h7E, 1'b1, 8'h00,
                3'b011, 32'h3000_0010, 8'h7E, 3'b111, 2'd0, 24'h00A500);
    tbl[5] = tbl[4];
    tbl[6] = tbl[4];
    tbl[7] = mk(3'b000, 3'b001, 32'h3000_0010, 8'h7E, 1'b0, 8'h3C,
                3'b011, 32'h3000_0010, 8'h7E, 3'b110, 2'd0, 24'h00A53C);
    tbl[8] = mk(3'b000, 3'b000, 32'h0, 8'h00, 1'b0, 8'h00,
                3'b000, 32'h3000_0010, 8'h7E, 3'b111, 2'd0, 24'h00A53C);

    // Reset state
    do_reset();
    #3;
    chk("rst_strobes", {mem_read, mem_write, busy}, 3'b000);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_writedata", mem_writedata, 8'h0);
    chk("rst_grant_idx", grant_idx, 2'd2);
    chk("rst_waitrequest", req_waitrequest, 3'b111);
    chk("rst_readdata", req_readdata, 24'h0);
    @(posedge clk); #1;

    // Single read, then a write stretched by three wait states
    for (int i = 0; i < 9; i++) begin
      req_read        = tbl[i].rd;
      req_write       = tbl[i].wr;
      req_address     = {NR{tbl[i].addr}};
      req_writedata   = {NR{tbl[i].wd}};
      mem_waitrequest = tbl[i].mw;
      mem_readdata    = tbl[i].mrd;
      #3;
      chk($sformatf("vec%0d_strobes", i), {mem_read, mem_write, busy}, tbl[i].e_strb);
      chk($sformatf("vec%0d_address", i), mem_address, tbl[i].e_addr);
      chk($sformatf("vec%0d_writedata", i), mem_writedata, tbl[i].e_wd);
      chk($sformatf("vec%0d_waitreq", i), req_waitrequest, tbl[i].e_wreq);
      chk($sformatf("vec%0d_grant", i), grant_idx, tbl[i].e_grant);
      chk($sformatf("vec%0d_readdata", i), req_readdata, tbl[i].e_rdata);
      @(posedge clk); #1;
    end

    // Round-robin with all three reading continuously
    do_reset();
    req_read = 3'b111;
    collect(6, 40);
    req_read = '0;
    for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), 64'(grant_at(i)), 64'(i % 3));

    // Lock limit: park the grant on 1, then 2 locks while 0 also waits
    do_reset();
    req_read = 3'b010;
    collect(1, 10);
    chk("lock_pre_grant", 64'(grant_at(0)), 64'd1);
    req_read = 3'b101;
    req_lock = 3'b100;
    collect(17, 80);
    req_read = '0;
    req_lock = '0;
    for (int i = 0; i < 17; i++)
      chk($sformatf("lock_grant%0d", i), 64'(grant_at(i)), (i < 16) ? 64'd2 : 64'd0);

    // Read and write together from requester 1
    req_read  = 3'b010;
    req_write = 3'b010;
    req_writedata = 24'h00_5A_00;
    @(posedge clk); #1;
    #3;
    chk("perr_strobes", {mem_read, mem_write}, 2'b01);
    chk("perr_writedata", mem_writedata, 8'h5A);
    chk("perr_flag", proto_err, 1'b1);
    @(posedge clk); #1;
    req_read  = 3'b001;
    req_write = '0;
    collect(1, 10);
    req_read = '0;
    chk("perr_clean_grant", 64'(grant_at(0)), 64'd0);
    chk("perr_sticky", proto_err, 1'b1);

    // Reset while a transfer is stalled
    req_read        = 3'b100;
    mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    #3;
    chk("mid_strobe_before", {mem_read, busy, grant_idx}, {1'b1, 1'b1, 2'd2});
    reset = 1'b1;
    #1;
    chk("mid_strobes_dropped", {mem_read, mem_write, busy}, 3'b000);
    chk("mid_waitreq", req_waitrequest, 3'b111);
    chk("mid_proto_cleared", proto_err, 1'b0);
    mem_waitrequest = 1'b0;
    #1;
    chk("mid_no_pulse", req_waitrequest, 3'b111);
    @(posedge clk); #1;
    reset    = 1'b0;
    req_read = 3'b101;
    collect(1, 10);
    req_read = '0;
    chk("mid_first_winner", 64'(grant_at(0)), 64'd0);

    // Randomized traffic against the reference model
    do_reset();
    m_busy = 1'b0; m_last = NR - 1; m_cnt = 0; m_w = 0; m_rdata = '0; done_prev = -1;
    a_act = '0; a_rd = '0; a_wr = '0; a_lock = '0;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (done_prev == i) a_act[i] = 1'b0;
        if (!a_act[i] && $urandom_range(0, 2) != 0) begin
          a_act[i]  = 1'b1;
          a_wr[i]   = 1'($urandom_range(0, 1));
          a_rd[i]   = ~a_wr[i];
          a_lock[i] = ($urandom_range(0, 3) == 0);
          a_addr[i] = $urandom;
          a_wd[i]   = 8'($urandom_range(0, 255));
        end
        req_read[i]              = a_act[i] & a_rd[i];
        req_write[i]             = a_act[i] & a_wr[i];
        req_lock[i]              = a_act[i] & a_lock[i];
        req_address[i*AW +: AW]  = a_addr[i];
        req_writedata[i*8 +: 8]  = a_wd[i];
      end
      mem_waitrequest = ($urandom_range(0, 2) == 0);
      mem_readdata    = 8'($urandom_range(0, 255));
      #3;
      done_prev = -1;
      pend = req_read | req_write;
      if (!m_busy) begin
        chk("rnd_idle_strobes", {mem_read, mem_write, busy}, 3'b000);
        chk("rnd_idle_waitreq", req_waitrequest, 3'b111);
        chk("rnd_idle_readdata", req_readdata, m_rdata);
        if (pend != '0) begin
          if (req_lock[m_last] && pend[m_last] && m_cnt < LM - 1) begin
            m_w = m_last;
            m_cnt++;
          end else begin
            m_cnt = 0;
            m_w   = -1;
            for (int k = 1; k <= NR; k++) begin
              cidx = (m_last + k) % NR;
              if (m_w < 0 && pend[cidx]) m_w = cidx;
            end
          end
          m_last = m_w;
          e_addr = a_addr[m_w];
          e_wd   = a_wd[m_w];
          e_rd   = a_rd[m_w] & ~a_wr[m_w];
          e_wr   = a_wr[m_w];
          m_busy = 1'b1;
        end
      end else begin
        chk("rnd_strobes", {mem_read, mem_write, busy}, {e_rd, e_wr, 1'b1});
        chk("rnd_address", mem_address, e_addr);
        chk("rnd_writedata", mem_writedata, e_wd);
        chk("rnd_grant", 64'(grant_idx), 64'(m_w));
        exp_wreq = '1;
        if (!mem_waitrequest) begin
          exp_wreq[m_w]       = 1'b0;
          m_rdata[m_w*8 +: 8] = mem_readdata;
          done_prev           = m_w;
          m_busy              = 1'b0;
        end
        chk("rnd_waitreq", req_waitrequest, exp_wreq);
        chk("rnd_readdata", req_readdata, m_rdata);
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/doom_mem_arbiter.md
Name: doom_mem_arbiter

Overview:
- Shares the single 8-bit shared-memory Avalon-MM master port (mem_*) between NUM_REQ internal requesters inside the Doom FPGA accelerator, e.g. patch fetch, palette load and column draw engines.
- Uses round-robin arbitration with an optional per-requester lock for back-to-back bursts, bounded by LOCK_MAX.
- Drives registered master outputs and returns Avalon waitrequest/readdata to the granted requester.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 32, address width
LOCK_MAX, 16, max consecutive transfers one requester may hold via lock before forced rotation

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_address  in  NUM_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
req_read  in  NUM_REQ  read request per requester
req_write  in  NUM_REQ  write request per requester
req_writedata  in  NUM_REQ*8  write data per requester
req_lock  in  NUM_REQ  keep grant after completion if still requesting
req_readdata  out  NUM_REQ*8  read data, valid in the completion cycle
req_waitrequest  out  NUM_REQ  Avalon waitrequest per requester
mem_address  out  ADDR_W  master address
mem_read  out  1  master read
mem_write  out  1  master write
mem_writedata  out  8  master write data
mem_readdata  in  8  master read data
mem_waitrequest  in  1  master waitrequest
grant_idx  out  $clog2(NUM_REQ)  index of last/current grant
busy  out  1  transfer in flight
proto_err  out  1  sticky: some requester asserted read and write together

Behaviour:
- Reset (async, immediate): state IDLE; mem_read, mem_write, busy and proto_err = 0; mem_address and mem_writedata = 0; grant_idx = NUM_REQ-1, so requester 0 has first priority; lock counter = 0; all req_waitrequest = 1; req_readdata = 0.
- Reset mid-transfer: master strobes drop immediately. The transfer is abandoned and never reported complete.
- req_waitrequest[i] is 1 in every cycle except the completion cycle of requester i's granted transfer. Requesters hold their command stable while waitrequest is 1.
- States:
  - IDLE: if any req_read|req_write is set, select the first requesting index scanning upward (with wrap) from grant_idx+1. Register its address, writedata, read and write into mem_*. Set busy = 1 and grant_idx = selection. Go to ISSUE. If nothing is requested, stay in IDLE.
  - ISSUE: hold mem_* stable while mem_waitrequest = 1.
    - When mem_waitrequest = 0 (completion cycle): req_waitrequest[grant_idx] = 0 and req_readdata[grant_idx] = mem_readdata, combinationally in this cycle. Other req_readdata lanes hold their previous value.
    - Next cycle: mem_read/mem_write = 0, busy = 0, go to IDLE.
- Latency: a request first seen in IDLE at cycle c puts the strobe on mem_* at c+1. Minimum 2 cycles per transfer; zero-wait-state memory completes at c+1.
- Lock:
  - In IDLE, if req_lock[grant_idx] = 1, requester grant_idx requests again, and lock count < LOCK_MAX-1, re-grant the same index and increment the count.
  - Otherwise do round-robin and clear the count.
  - Reaching LOCK_MAX consecutive grants forces rotation when another requester is pending. With no other requester pending, the same requester is granted again and the count resets to 0.
- Read and write asserted together by one requester: treated as a write (mem_read = 0). proto_err sets and stays set until reset.
- Requester deasserting its request mid-transfer: illegal. The latched command still completes and the completion pulse is still given.
- Simultaneous requests from all: strict rotation 0,1,2,0…, so no starvation.
- At most one master transaction is outstanding; there is no pipelining.

Test Plan:
- Single read: req 1 reads 0x3000_0004 with mem_waitrequest = 0 and mem_readdata = 0xA5 → mem_read = 1 with mem_address = 0x3000_0004 one cycle after the request; req_waitrequest[1] = 0 and req_readdata[1] = 0xA5 in that cycle; busy = 0 the next cycle.
- Wait states: req 0 writes 0x7E to 0x3000_0010 while mem_waitrequest is held 1 for 3 cycles → mem_* stable for 4 cycles; req_waitrequest[0] low exactly once.
- Round-robin: all three requesters issue continuous reads → grants are 0,1,2,0,1,2 across 6 transfers.
- Lock limit: req 2 has lock = 1 and requests continuously while req 0 also requests, LOCK_MAX = 16 → 16 consecutive grants to 2, then 1 grant to 0.
- Protocol error: req 1 asserts read and write together → mem_write = 1, mem_read = 0, proto_err = 1 and stays 1 after later clean transfers.
- Reset mid-transfer: assert reset during ISSUE with mem_waitrequest = 1 → mem_read = 0 and busy = 0 immediately; no req_waitrequest low pulse; after release, requester 0 wins first.
